int_sched: RTL and testbench

Interrupt scheduler for the interrupt-capable five-stage pipeline. It latches edge-triggered requests from `NSRC` sources and arbitrates them by fixed priority. It decides when an interrupt may enter the pipeline and drives the `Int_Enter` / `IRS` inputs of the ID/EX pipeline register. It also tracks nested service levels, popping a level on each `uret` that reaches EX.

---
 rtl/int_sched_pkg.sv | 22 ++
 rtl/int_sched_if.sv | 32 +++
 rtl/int_sched_lvl_stack.sv | 40 ++++
 rtl/int_sched.sv | 131 +++++++++++++
 tb/tb_int_sched.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/int_sched_pkg.sv
// Shared definitions for the interrupt scheduler.
// Level encoding, FSM state codes and IRS one-hot helper.
package int_sched_pkg;

  localparam int LVL_W = 2;
  localparam int IRS_W = 3;

  localparam logic [LVL_W-1:0] LVL_NONE = '0;

  typedef logic [1:0] sched_st_t;

  localparam sched_st_t S_RUN   = 2'd0;
  localparam sched_st_t S_ENTER = 2'd1;
  localparam sched_st_t S_HOLD  = 2'd2;

  function automatic logic [IRS_W-1:0] irs_of(
    input logic [LVL_W-1:0] idx
  );
    return IRS_W'(1) << idx;
  endfunction

endpackage

// File: rtl/int_sched_if.sv
// Request/entry bundle between the pipeline core and int_sched.
// master = core side, slave = scheduler side.
interface int_sched_if
  import int_sched_pkg::*;
#(
  parameter int NSRC = 3
);

  logic [NSRC-1:0]  irq;
  logic             ie;
  logic             pipe_ok;
  logic             uret_ex;
  logic             int_enter;
  logic [IRS_W-1:0] irs;
  logic [LVL_W-1:0] cur_level;
  logic [NSRC-1:0]  pending;
  logic [LVL_W-1:0] depth;
  logic             uret_err;

  modport master (
    output irq, ie, pipe_ok, uret_ex,
    input  int_enter, irs, cur_level,
    input  pending, depth, uret_err
  );

  modport slave (
    input  irq, ie, pipe_ok, uret_ex,
    output int_enter, irs, cur_level,
    output pending, depth, uret_err
  );

endinterface

// File: rtl/int_sched_lvl_stack.sv
// Stack of saved service levels for nested interrupts.
// Push with pop in one cycle replaces the top with din.
module lvl_stack #(
  parameter int DEPTH = 3,
  parameter int W     = 2,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_din,
  output logic [W-1:0]  o_dout,
  output logic [DW-1:0] o_depth
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [DW-1:0] r_depth;
  logic [DW-1:0] w_top;

  assign w_top   = r_depth - 1'b1;
  assign o_dout  = (r_depth == '0) ? '0 : r_mem[w_top];
  assign o_depth = r_depth;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_depth <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (i_push && i_pop) begin
      r_mem[w_top] <= i_din;
    end else if (i_push) begin
      r_mem[r_depth] <= i_din;
      r_depth        <= r_depth + 1'b1;
    end else if (i_pop) begin
      r_depth <= r_depth - 1'b1;
    end
  end

endmodule

// File: rtl/int_sched.sv
// Edge-latched, fixed-priority interrupt scheduler with
// nested level tracking and a post-entry guard window.
module int_sched
  import int_sched_pkg::*;
#(
  parameter int NSRC  = 3,
  parameter int GUARD = 2
) (
  input logic       clk,
  input logic       rst,
  int_sched_if.slave io
);

  localparam int CW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

  sched_st_t        r_state;
  logic [NSRC-1:0]  r_irq_q;
  logic [NSRC-1:0]  r_pending;
  logic [LVL_W-1:0] r_cur_level;
  logic [IRS_W-1:0] r_irs;
  logic             r_uret_err;
  logic [CW-1:0]    r_cnt;

  logic [NSRC-1:0]  w_rise;
  logic [NSRC-1:0]  w_clr;
  logic             w_has_cand;
  logic [LVL_W-1:0] w_cand_idx;
  logic [LVL_W-1:0] w_cand_lvl;
  logic             w_uret_ok;
  logic             w_pop;
  logic             w_accept;
  logic [LVL_W-1:0] w_top;
  logic [LVL_W-1:0] w_eff_lvl;
  logic [LVL_W-1:0] w_depth;

  assign w_rise = io.irq & ~r_irq_q;

  always_comb begin
    w_has_cand = 1'b0;
    w_cand_idx = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (r_pending[i]) begin
        w_has_cand = 1'b1;
        w_cand_idx = i[LVL_W-1:0];
      end
    end
  end

  assign w_cand_lvl = w_cand_idx + 1'b1;

  // A uret pops before the accept compare sees cur_level.
  assign w_uret_ok = io.uret_ex && (r_state != S_ENTER);
  assign w_pop     = w_uret_ok && (w_depth != '0);
  assign w_eff_lvl = w_pop ? w_top : r_cur_level;

  assign w_accept = (r_state == S_RUN) && io.ie
                 && io.pipe_ok && w_has_cand
                 && (w_cand_lvl > w_eff_lvl);

  always_comb begin
    w_clr = '0;
    if (w_accept)
      w_clr[w_cand_idx] = 1'b1;
  end

  lvl_stack #(
    .DEPTH (NSRC),
    .W     (LVL_W),
    .DW    (LVL_W)
  ) u_stack (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_accept),
    .i_pop   (w_pop),
    .i_din   (w_eff_lvl),
    .o_dout  (w_top),
    .o_depth (w_depth)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_irq_q     <= '0;
      r_pending   <= '0;
      r_cur_level <= LVL_NONE;
      r_irs       <= '0;
      r_uret_err  <= 1'b0;
    end else begin
      r_irq_q    <= io.irq;
      r_pending  <= (r_pending & ~w_clr) | w_rise;
      r_uret_err <= w_uret_ok && (w_depth == '0);
      if (w_accept) begin
        r_cur_level <= w_cand_lvl;
        r_irs       <= irs_of(w_cand_idx);
      end else if (w_pop) begin
        r_cur_level <= w_top;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
    end else begin
      unique case (1'b1)
        (r_state == S_RUN): begin
          if (w_accept)
            r_state <= S_ENTER;
        end
        (r_state == S_ENTER): begin
          r_cnt   <= CW'(GUARD);
          r_state <= (GUARD > 0) ? S_HOLD : S_RUN;
        end
        (r_state == S_HOLD): begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt <= CW'(1))
            r_state <= S_RUN;
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign io.int_enter = (r_state == S_ENTER);
  assign io.irs       = r_irs;
  assign io.cur_level = r_cur_level;
  assign io.pending   = r_pending;
  assign io.depth     = w_depth;
  assign io.uret_err  = r_uret_err;

endmodule

// File: tb/tb_int_sched.sv
// Directed bench for int_sched: entry, priority, nesting,
// gating, uret errors and asynchronous reset.
module tb_int_sched;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  int_sched_if #(.NSRC(3)) bus ();

  int_sched #(
    .NSRC  (3),
    .GUARD (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag,
                         input logic       en,
                         input logic [2:0] irs,
                         input logic [1:0] lvl,
                         input logic [2:0] pend,
                         input logic [1:0] dep);
    chk({tag, ".enter"}, 32'(bus.int_enter), 32'(en));
    chk({tag, ".irs"},   32'(bus.irs),       32'(irs));
    chk({tag, ".level"}, 32'(bus.cur_level), 32'(lvl));
    chk({tag, ".pend"},  32'(bus.pending),   32'(pend));
    chk({tag, ".depth"}, 32'(bus.depth),     32'(dep));
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b0;
    bus.irq     = 3'b000;
    bus.ie      = 1'b0;
    bus.pipe_ok = 1'b0;
    bus.uret_ex = 1'b0;
    #2;
    chk_all("reset", 1'b0, 3'b000, 2'd0, 3'b000, 2'd0);
    chk("reset.err", 32'(bus.uret_err), 32'd0);
    step();
    step();
    rst         = 1'b1;
    bus.ie      = 1'b1;
    bus.pipe_ok = 1'b1;
    step();

    // single entry on source 0
    bus.irq = 3'b001;
    step();
    chk_all("s0.pend", 1'b0, 3'b000, 2'd0, 3'b001, 2'd0);
    step();
    chk_all("s0.enter", 1'b1, 3'b001, 2'd1, 3'b000, 2'd1);

    // nesting: source 1 arrives during the guard window
    bus.irq = 3'b011;
    step();
    chk_all("n1.hold1", 1'b0, 3'b001, 2'd1, 3'b010, 2'd1);
    step();
    chk_all("n1.hold2", 1'b0, 3'b001, 2'd1, 3'b010, 2'd1);
    step();
    chk_all("n1.run", 1'b0, 3'b001, 2'd1, 3'b010, 2'd1);
    step();
    chk_all("n1.enter", 1'b1, 3'b010, 2'd2, 3'b000, 2'd2);

    // lower-level request is held off
    bus.irq = 3'b010;
    step();
    bus.irq = 3'b011;
    step();
    chk_all("low.pend", 1'b0, 3'b010, 2'd2, 3'b001, 2'd2);
    step();
    step();
    chk_all("low.block", 1'b0, 3'b010, 2'd2, 3'b001, 2'd2);

    // first uret pops to level 1; source 0 still blocked
    bus.uret_ex = 1'b1;
    step();
    chk_all("uret1", 1'b0, 3'b010, 2'd1, 3'b001, 2'd1);
    // second uret pops to 0 and source 0 enters same cycle
    step();
    bus.uret_ex = 1'b0;
    chk_all("uret2.acc", 1'b1, 3'b001, 2'd1, 3'b000, 2'd1);
    step();
    bus.uret_ex = 1'b1;
    step();
    chk_all("uret.hold", 1'b0, 3'b001, 2'd0, 3'b000, 2'd0);
    step();
    bus.uret_ex = 1'b0;
    chk_all("uerr.outs", 1'b0, 3'b001, 2'd0, 3'b000, 2'd0);
    chk("uerr.pulse", 32'(bus.uret_err), 32'd1);
    step();
    chk("uerr.clear", 32'(bus.uret_err), 32'd0);

    // simultaneous rises on sources 0 and 2
    bus.irq = 3'b000;
    step();
    bus.irq = 3'b101;
    step();
    chk_all("sim.pend", 1'b0, 3'b001, 2'd0, 3'b101, 2'd0);
    step();
    chk_all("sim.enter2", 1'b1, 3'b100, 2'd3, 3'b001, 2'd1);
    step();
    step();
    step();
    chk_all("sim.wait", 1'b0, 3'b100, 2'd3, 3'b001, 2'd1);
    bus.uret_ex = 1'b1;
    step();
    bus.uret_ex = 1'b0;
    chk_all("sim.enter0", 1'b1, 3'b001, 2'd1, 3'b000, 2'd1);
    step();
    step();
    step();

    // pipe_ok gating
    bus.pipe_ok = 1'b0;
    bus.irq     = 3'b111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_all("gate", 1'b0, 3'b001, 2'd1, 3'b010, 2'd1);
    end
    bus.pipe_ok = 1'b1;
    step();
    chk_all("gate.enter", 1'b1, 3'b010, 2'd2, 3'b000, 2'd2);

    // asynchronous reset while int_enter is high
    #2;
    rst = 1'b0;
    #1;
    chk_all("rst.mid", 1'b0, 3'b000, 2'd0, 3'b000, 2'd0);
    chk("rst.err", 32'(bus.uret_err), 32'd0);
    bus.irq = 3'b000;
    #2;
    rst = 1'b1;
    step();
    chk_all("rst.idle", 1'b0, 3'b000, 2'd0, 3'b000, 2'd0);
    bus.irq = 3'b010;
    step();
    chk_all("rst.pend", 1'b0, 3'b000, 2'd0, 3'b010, 2'd0);
    step();
    chk_all("rst.enter", 1'b1, 3'b010, 2'd2, 3'b000, 2'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
